// File: rtl/clkgen_sched.sv
// ---------------------------------------------------------------------------
// clkgen_sched: programmable waveform scheduler.
//
// After a start request the block waits an initial phase delay. It then repeats
// a high interval of ton cycles followed by a low interval of toff cycles on
// wave_out_o. A configuration accepted while running is held in a shadow copy.
// That copy becomes active at the next period boundary, so a period is never cut
// short. All outputs are registered.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous reset, active high
//   start_i        run request (only looked at while idle)
//   stop_i         abort request (any state; wins over start_i)
//   cfg_valid_i    configuration offer
//   cfg_ready_o    configuration accept (low while a shadow config is pending)
//   cfg_phase_i    initial delay in clock cycles
//   cfg_ton_i      high time in clock cycles
//   cfg_toff_i     low time in clock cycles
//   cfg_err_o      one-cycle pulse when an offered config has ton==0 && toff==0
//   wave_out_o     generated waveform
//   running_o      high while in PHASE/HIGH/LOW
//   period_done_o  high during the last cycle of every period
//   period_cnt_o   periods completed since the last start (wraps)
// ---------------------------------------------------------------------------
module clkgen_sched #(
    parameter int CNT_W  = 16,
    parameter int PCNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CNT_W-1:0]  cfg_phase_i,
    input  logic [CNT_W-1:0]  cfg_ton_i,
    input  logic [CNT_W-1:0]  cfg_toff_i,
    output logic              cfg_err_o,
    output logic              wave_out_o,
    output logic              running_o,
    output logic              period_done_o,
    output logic [PCNT_W-1:0] period_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PHASE = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // First segment of a period: HIGH when ton>0, otherwise straight to LOW.
    // Returns {state, counter load value}.
    function automatic logic [CNT_W+1:0] first_seg(input logic [CNT_W-1:0] ton,
                                                   input logic [CNT_W-1:0] toff);
        logic [CNT_W+1:0] r;
        if (ton != CNT_ZERO) begin
            r = {S_HIGH, ton - CNT_ONE};
        end else begin
            r = {S_LOW, toff - CNT_ONE};
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    act_phase_q, act_phase_d;
    logic [CNT_W-1:0]    act_ton_q, act_ton_d;
    logic [CNT_W-1:0]    act_toff_q, act_toff_d;
    logic [CNT_W-1:0]    sh_phase_q, sh_phase_d;
    logic [CNT_W-1:0]    sh_ton_q, sh_ton_d;
    logic [CNT_W-1:0]    sh_toff_q, sh_toff_d;
    logic                loaded_q, loaded_d;
    logic                pend_q, pend_d;
    logic                wave_q, wave_d;
    logic                run_q, run_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;

    logic                cfg_fire_s;
    logic                cfg_zero_s;
    logic                cfg_ok_s;
    logic                start_ok_s;
    logic                per_end_s;
    logic [CNT_W+1:0]    seg_s;

    // Handshake qualification shared by the next-state and output logic.
    always_comb begin
        cfg_fire_s = cfg_valid_i & ready_q;
        cfg_zero_s = (cfg_ton_i == CNT_ZERO) && (cfg_toff_i == CNT_ZERO);
        cfg_ok_s   = cfg_fire_s & ~cfg_zero_s;
        start_ok_s = (state_q == S_IDLE) && start_i && !stop_i && (loaded_q || cfg_ok_s);
    end

    // State and configuration register bank.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            act_phase_q <= CNT_ZERO;
            act_ton_q   <= CNT_ZERO;
            act_toff_q  <= CNT_ZERO;
            sh_phase_q  <= CNT_ZERO;
            sh_ton_q    <= CNT_ZERO;
            sh_toff_q   <= CNT_ZERO;
            loaded_q    <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_phase_q <= act_phase_d;
            act_ton_q   <= act_ton_d;
            act_toff_q  <= act_toff_d;
            sh_phase_q  <= sh_phase_d;
            sh_ton_q    <= sh_ton_d;
            sh_toff_q   <= sh_toff_d;
            loaded_q    <= loaded_d;
            pend_q      <= pend_d;
        end
    end

    // Next-state, counter and config update logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_phase_d = act_phase_q;
        act_ton_d   = act_ton_q;
        act_toff_d  = act_toff_q;
        sh_phase_d  = sh_phase_q;
        sh_ton_d    = sh_ton_q;
        sh_toff_d   = sh_toff_q;
        loaded_d    = loaded_q;
        pend_d      = pend_q;
        per_end_s   = 1'b0;
        seg_s       = {S_IDLE, CNT_ZERO};

        // While idle a legal config goes straight to the active set.
        // While running it waits in the shadow set.
        if (cfg_ok_s) begin
            if (state_q == S_IDLE) begin
                act_phase_d = cfg_phase_i;
                act_ton_d   = cfg_ton_i;
                act_toff_d  = cfg_toff_i;
                loaded_d    = 1'b1;
            end else begin
                sh_phase_d  = cfg_phase_i;
                sh_ton_d    = cfg_ton_i;
                sh_toff_d   = cfg_toff_i;
                pend_d      = 1'b1;
            end
        end else begin
            loaded_d = loaded_q;
        end

        case (state_q)
            S_IDLE: begin
                // act_*_d already reflects a transfer made in this same cycle.
                if (start_ok_s) begin
                    if (act_phase_d != CNT_ZERO) begin
                        state_d = S_PHASE;
                        cnt_d   = act_phase_d - CNT_ONE;
                    end else begin
                        seg_s   = first_seg(act_ton_d, act_toff_d);
                        state_d = state_t'(seg_s[CNT_W+1:CNT_W]);
                        cnt_d   = seg_s[CNT_W-1:0];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PHASE: begin
                if (cnt_q == CNT_ZERO) begin
                    seg_s   = first_seg(act_ton_q, act_toff_q);
                    state_d = state_t'(seg_s[CNT_W+1:CNT_W]);
                    cnt_d   = seg_s[CNT_W-1:0];
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HIGH: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (act_toff_q != CNT_ZERO) begin
                    state_d = S_LOW;
                    cnt_d   = act_toff_q - CNT_ONE;
                end else begin
                    per_end_s = 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    per_end_s = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // A period boundary is where a pending shadow config takes effect.
        // The next period then starts from whichever config is active.
        if (per_end_s) begin
            if (pend_q) begin
                act_phase_d = sh_phase_q;
                act_ton_d   = sh_ton_q;
                act_toff_d  = sh_toff_q;
                pend_d      = 1'b0;
            end else begin
                pend_d = pend_d;
            end
            seg_s   = first_seg(act_ton_d, act_toff_d);
            state_d = state_t'(seg_s[CNT_W+1:CNT_W]);
            cnt_d   = seg_s[CNT_W-1:0];
        end else begin
            seg_s = seg_s;
        end

        // Abort overrides everything else and drops any pending shadow config.
        if (stop_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            pend_d  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe.
    always_comb begin
        wave_d  = (state_d == S_HIGH);
        run_d   = (state_d != S_IDLE);
        done_d  = ((state_d == S_LOW) && (cnt_d == CNT_ZERO)) ||
                  ((state_d == S_HIGH) && (cnt_d == CNT_ZERO) && (act_toff_d == CNT_ZERO));
        err_d   = cfg_fire_s & cfg_zero_s;
        ready_d = ~pend_d;
        if (start_ok_s) begin
            pcnt_d = {{(PCNT_W-1){1'b0}}, done_d};
        end else begin
            pcnt_d = pcnt_q + {{(PCNT_W-1){1'b0}}, done_d};
        end
    end

    // Output register bank.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wave_q  <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            pcnt_q  <= {PCNT_W{1'b0}};
        end else begin
            wave_q  <= wave_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign wave_out_o    = wave_q;
    assign running_o     = run_q;
    assign period_done_o = done_q;
    assign cfg_err_o     = err_q;
    assign cfg_ready_o   = ready_q;
    assign period_cnt_o  = pcnt_q;

endmodule

// File: tb/tb_clkgen_sched.sv
// Directed bench for clkgen_sched. Each scenario queues the per-cycle outputs
// it expects (wave, period_done, running, cfg_ready). These values come from the
// phase/ton/toff arithmetic. They are then popped and compared one cycle at a time.
module tb_clkgen_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, stop_i, cfg_valid_i;
    logic        cfg_ready_o, cfg_err_o, wave_out_o, running_o, period_done_o;
    logic [15:0] cfg_phase_i, cfg_ton_i, cfg_toff_i;
    logic [15:0] period_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic wave;
        logic done;
        logic run;
        logic rdy;
    } exp_t;

    exp_t sb[$];

    clkgen_sched #(.CNT_W(16), .PCNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_phase_i(cfg_phase_i), .cfg_ton_i(cfg_ton_i), .cfg_toff_i(cfg_toff_i),
        .cfg_err_o(cfg_err_o), .wave_out_o(wave_out_o), .running_o(running_o),
        .period_done_o(period_done_o), .period_cnt_o(period_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs for a run: phase idle cycles, then ton-high/toff-low periods.
    task automatic push_wave(input int phase, input int ton, input int toff,
                             input int n, input logic rdy);
        for (int j = 1; j <= n; j++) begin
            exp_t e;
            int   t;
            if (j <= phase) begin
                e = '{wave: 1'b0, done: 1'b0, run: 1'b1, rdy: rdy};
            end else begin
                t = (j - 1 - phase) % (ton + toff);
                e = '{wave: (t < ton), done: (t == ton + toff - 1), run: 1'b1, rdy: rdy};
            end
            sb.push_back(e);
        end
    endtask

    task automatic push_one(input logic w, input logic d, input logic r, input logic rdy);
        exp_t e;
        e = '{wave: w, done: d, run: r, rdy: rdy};
        sb.push_back(e);
    endtask

    // Advance one cycle and compare the DUT against the oldest queued expectation.
    task automatic step(input string tag);
        exp_t e;
        @(negedge clk_i);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wave"}, {31'd0, wave_out_o}, {31'd0, e.wave});
            chk({tag, "_done"}, {31'd0, period_done_o}, {31'd0, e.done});
            chk({tag, "_run"}, {31'd0, running_o}, {31'd0, e.run});
            chk({tag, "_rdy"}, {31'd0, cfg_ready_o}, {31'd0, e.rdy});
        end
    endtask

    task automatic drive_cfg(input logic v, input int ph, input int ton, input int toff);
        cfg_valid_i = v;
        cfg_phase_i = ph[15:0];
        cfg_ton_i   = ton[15:0];
        cfg_toff_i  = toff[15:0];
    endtask

    task automatic do_stop(input string tag);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk({tag, "_stop_run"}, {31'd0, running_o}, 32'd0);
        chk({tag, "_stop_wave"}, {31'd0, wave_out_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
        drive_cfg(1'b0, 0, 0, 0);
        #12;
        chk("rst_wave", {31'd0, wave_out_o}, 32'd0);
        chk("rst_run", {31'd0, running_o}, 32'd0);
        chk("rst_rdy", {31'd0, cfg_ready_o}, 32'd1);
        chk("rst_cnt", {16'd0, period_cnt_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // 1: phase=2 ton=3 toff=2, idle load then start.
        drive_cfg(1'b1, 2, 3, 2);
        @(negedge clk_i);
        drive_cfg(1'b0, 0, 0, 0);
        push_wave(2, 3, 2, 13, 1'b1);
        start_i = 1'b1;
        step("t1");
        start_i = 1'b0;
        for (int j = 2; j <= 13; j++) step("t1");
        chk("t1_pcnt", {16'd0, period_cnt_o}, 32'd2);
        do_stop("t1");

        // 2: shadow update mid-HIGH, applied at the period boundary.
        drive_cfg(1'b1, 0, 3, 2);
        @(negedge clk_i);
        drive_cfg(1'b0, 0, 0, 0);
        for (int j = 1; j <= 5; j++) push_one(j <= 3, j == 5, 1'b1, j <= 2);
        push_wave(0, 1, 1, 4, 1'b1);
        start_i = 1'b1;
        step("t2");
        start_i = 1'b0;
        step("t2");
        drive_cfg(1'b1, 0, 1, 1);
        step("t2");
        drive_cfg(1'b0, 0, 0, 0);
        for (int j = 4; j <= 9; j++) step("t2");
        do_stop("t2");

        // 3: all-zero offer is rejected; the old 1/1 config is still used.
        drive_cfg(1'b1, 5, 0, 0);
        @(negedge clk_i);
        drive_cfg(1'b0, 0, 0, 0);
        chk("t3_err_pulse", {31'd0, cfg_err_o}, 32'd1);
        chk("t3_err_rdy", {31'd0, cfg_ready_o}, 32'd1);
        @(negedge clk_i);
        chk("t3_err_clear", {31'd0, cfg_err_o}, 32'd0);
        push_wave(0, 1, 1, 4, 1'b1);
        start_i = 1'b1;
        step("t3");
        start_i = 1'b0;
        for (int j = 2; j <= 4; j++) step("t3");
        do_stop("t3");

        // 4: toff=0 with a config transfer in the same cycle as start.
        push_wave(1, 4, 0, 9, 1'b1);
        drive_cfg(1'b1, 1, 4, 0);
        start_i = 1'b1;
        step("t4");
        start_i = 1'b0;
        drive_cfg(1'b0, 0, 0, 0);
        for (int j = 2; j <= 9; j++) step("t4");
        chk("t4_pcnt", {16'd0, period_cnt_o}, 32'd2);
        do_stop("t4");

        // 5: start&stop together stays idle; stop in HIGH drops the pending shadow.
        drive_cfg(1'b1, 0, 3, 2);
        @(negedge clk_i);
        drive_cfg(1'b0, 0, 0, 0);
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; stop_i = 1'b0;
        chk("t5_ss_run", {31'd0, running_o}, 32'd0);
        @(negedge clk_i);
        chk("t5_ss_run2", {31'd0, running_o}, 32'd0);
        push_one(1'b1, 1'b0, 1'b1, 1'b1);
        push_one(1'b1, 1'b0, 1'b1, 1'b0);
        start_i = 1'b1;
        step("t5");
        start_i = 1'b0;
        drive_cfg(1'b1, 0, 2, 2);
        step("t5");
        drive_cfg(1'b0, 0, 0, 0);
        do_stop("t5");
        chk("t5_pend_clr", {31'd0, cfg_ready_o}, 32'd1);
        push_wave(0, 3, 2, 6, 1'b1);
        start_i = 1'b1;
        step("t5r");
        start_i = 1'b0;
        for (int j = 2; j <= 6; j++) step("t5r");
        do_stop("t5r");

        // 6: async reset mid-LOW in the second period, then start without config.
        push_wave(0, 3, 2, 9, 1'b1);
        start_i = 1'b1;
        step("t6");
        start_i = 1'b0;
        for (int j = 2; j <= 9; j++) step("t6");
        chk("t6_pre_cnt", {16'd0, period_cnt_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_rst_run", {31'd0, running_o}, 32'd0);
        chk("t6_rst_cnt", {16'd0, period_cnt_o}, 32'd0);
        chk("t6_rst_rdy", {31'd0, cfg_ready_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("t6_nocfg_run", {31'd0, running_o}, 32'd0);
            chk("t6_nocfg_wave", {31'd0, wave_out_o}, 32'd0);
            @(negedge clk_i);
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
